// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with input FIFO, runtime baud prescale,
// optional parity and one or two stop bits.
// Ports:
//   CLK        - system clock, rising edge
//   RST        - synchronous active-low reset
//   P_DATA     - parallel word to queue
//   DATA_VALID - host write strobe
//   DATA_READY - FIFO not full (registered)
//   PAR_EN     - insert parity bit
//   PAR_TYP    - 0 even, 1 odd parity
//   STOP2      - 0 one stop bit, 1 two stop bits
//   PRESCALE   - clocks per serial bit (0 treated as 1)
//   TX_OUT     - registered serial line, idle high
//   BUSY       - frame in progress or FIFO non-empty
module uart_tx_param #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_W-1:0]     P_DATA,
  input  logic                  DATA_VALID,
  output logic                  DATA_READY,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BW = $clog2(DATA_W);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state, state_n;
  logic [DATA_W-1:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          count, count_n;
  logic                   push, pop, load, fifo_empty, tick;
  logic [DATA_W-1:0]      head, shreg, shreg_n;
  logic [PRESCALE_W-1:0]  presc_cnt, presc_cnt_n, presc_q;
  logic [BW-1:0]          bit_cnt, bit_cnt_n;
  logic                   tx_n;
  logic                   par_en_q, parity_q, stop2_q;

  assign push       = DATA_VALID && DATA_READY;
  assign fifo_empty = (count == '0);
  assign head       = mem[rd_ptr];
  assign count_n    = count + CW'(push) - CW'(pop);
  assign tick       = (presc_cnt == presc_q - PRESCALE_W'(1));

  // FIFO storage; stale entries are harmless because pointers are reset
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= P_DATA;
  end

  // FIFO pointers, occupancy and registered ready
  always_ff @(posedge CLK) begin
    if (!RST) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      DATA_READY <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count      <= count_n;
      DATA_READY <= (count_n != CW'(FIFO_DEPTH));
    end
  end

  // FSM state and datapath registers
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= IDLE;
      presc_cnt <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      TX_OUT    <= 1'b1;
      BUSY      <= 1'b0;
      presc_q   <= PRESCALE_W'(1);
      par_en_q  <= 1'b0;
      parity_q  <= 1'b0;
      stop2_q   <= 1'b0;
    end else begin
      state     <= state_n;
      presc_cnt <= presc_cnt_n;
      bit_cnt   <= bit_cnt_n;
      shreg     <= shreg_n;
      TX_OUT    <= tx_n;
      BUSY      <= (state_n != IDLE) || (count_n != '0);
      // frame-constant configuration captured with the popped word
      if (load) begin
        presc_q  <= (PRESCALE == '0) ? PRESCALE_W'(1) : PRESCALE;
        par_en_q <= PAR_EN;
        parity_q <= (^head) ^ PAR_TYP;
        stop2_q  <= STOP2;
      end
    end
  end

  // Next-state, pop and serial bit selection
  always_comb begin
    state_n     = state;
    presc_cnt_n = '0;
    bit_cnt_n   = bit_cnt;
    shreg_n     = shreg;
    tx_n        = TX_OUT;
    pop         = 1'b0;
    load        = 1'b0;
    if (state != IDLE) presc_cnt_n = tick ? '0 : presc_cnt + PRESCALE_W'(1);
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (!fifo_empty) begin
          pop       = 1'b1;
          load      = 1'b1;
          shreg_n   = head;
          bit_cnt_n = '0;
          tx_n      = 1'b0;
          state_n   = START;
        end
      end
      START: begin
        if (tick) begin
          tx_n      = shreg[0];
          bit_cnt_n = '0;
          state_n   = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_cnt == BW'(DATA_W - 1)) begin
            bit_cnt_n = '0;
            if (par_en_q) begin
              tx_n    = parity_q;
              state_n = PARITY;
            end else begin
              tx_n    = 1'b1;
              state_n = STOP;
            end
          end else begin
            bit_cnt_n = bit_cnt + BW'(1);
            shreg_n   = shreg >> 1;
            tx_n      = shreg[1];
          end
        end
      end
      PARITY: begin
        if (tick) begin
          tx_n      = 1'b1;
          bit_cnt_n = '0;
          state_n   = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          if (stop2_q && (bit_cnt == '0)) begin
            bit_cnt_n = BW'(1);
          end else if (!fifo_empty) begin
            // chain straight into the next frame, no idle gap
            pop       = 1'b1;
            load      = 1'b1;
            shreg_n   = head;
            bit_cnt_n = '0;
            tx_n      = 1'b0;
            state_n   = START;
          end else begin
            tx_n    = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: begin
        tx_n    = 1'b1;
        state_n = IDLE;
      end
    endcase
  end

endmodule
